xnor_reduce_acc: RTL and testbench

Parametrised, streaming successor to the fixed 3-input XNOR gate. It reduces WIDTH-bit input words to one parity bit, XNOR or XOR, and accumulates that parity across a multi-word frame delimited by `in_last`. The frame result and its beat count are presented on a valid/ready output register. It sits between a word source and any consumer that needs per-frame parity or equivalence checking.

---
 rtl/xnor_reduce_acc.sv | 67 ++++++
 tb/tb_xnor_reduce_acc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/xnor_reduce_acc.sv
// xnor_reduce_acc: per-frame XNOR/XOR parity accumulator with saturating beat count and valid/ready result register
module xnor_reduce_acc #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             in_frame;
  logic             take;
  logic             x;
  logic             mode_eff;
  logic [CNT_W-1:0] cnt_nx;
  always_comb begin
    in_ready = rst_n && (!out_valid || out_ready);
    take     = in_valid && in_ready;
    x        = in_frame ? acc ^ (^in_data) : ^in_data;
    mode_eff = in_frame ? mode_q : mode;
    cnt_nx   = !in_frame ? CNT_W'(1) : (cnt == CNT_MAX ? cnt : cnt + CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      in_frame   <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (take && !in_frame)
        mode_q <= mode;
      if (take && in_last) begin
        out_valid  <= 1'b1;
        out_parity <= mode_eff ? x : ~x;
        out_count  <= cnt_nx;
        out_sat    <= cnt_nx == CNT_MAX;
        acc        <= 1'b0;
        cnt        <= '0;
        in_frame   <= 1'b0;
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        if (take) begin
          acc      <= x;
          cnt      <= cnt_nx;
          in_frame <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_xnor_reduce_acc.sv
// tb_xnor_reduce_acc: table vectors plus multi-cycle sequences, scoreboard-checked on two counter widths
module tb_xnor_reduce_acc;
  typedef struct {
    logic [2:0] data;
    logic       mode;
    logic       par;
  } vec_t;
  typedef struct {
    logic par;
    int   n;
  } exp_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic [2:0] in_data = '0;
  logic       in_last = 0;
  logic       mode = 0;
  logic       out_ready = 1;
  logic       in_ready, in_ready2;
  logic       out_valid, out_valid2;
  logic       out_parity, out_parity2;
  logic [7:0] out_count;
  logic [1:0] out_count2;
  logic       out_sat, out_sat2;
  int         tests = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       sb[$];
  logic       fresh = 1;
  logic       m_acc = 0;
  logic       m_mode = 0;
  int         m_n = 0;
  vec_t       tab[16];

  xnor_reduce_acc #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_parity(out_parity), .out_count(out_count), .out_sat(out_sat)
  );
  xnor_reduce_acc #(.WIDTH(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_parity(out_parity2), .out_count(out_count2), .out_sat(out_sat2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // A result is fresh after an edge where the register could load a new one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && fresh) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("parity", out_parity, e.par);
        chk("count8", out_count, e.n > 255 ? 255 : e.n);
        chk("sat8", out_sat, e.n >= 255);
        chk("valid2", out_valid2, 1);
        chk("parity2", out_parity2, e.par);
        chk("count2", out_count2, e.n > 3 ? 3 : e.n);
        chk("sat2", out_sat2, e.n >= 3);
      end
    end
    fresh = !out_valid || out_ready;
  end

  task automatic beat(input logic [2:0] d, input logic last, input logic m, input logic auto_push);
    logic ok;
    exp_t e;
    in_valid = 1; in_data = d; in_last = last; mode = m;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk) ok = in_ready;
      @(posedge clk) #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (m_n == 0) m_mode = m;
    m_acc ^= ^d;
    m_n++;
    if (last) begin
      e.par = m_mode ? m_acc : ~m_acc;
      e.n = m_n;
      if (auto_push) sb.push_back(e);
      m_acc = 0; m_n = 0;
    end
  endtask

  task automatic idle();
    in_valid = 0; in_data = 3'bxxx; in_last = 1'bx; mode = 1'bx;
  endtask

  initial begin
    int t0;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      tab[i].data = 3'(i); tab[i].mode = 0;
      tab[i + 8].data = 3'(i); tab[i + 8].mode = 1;
    end
    {tab[0].par, tab[1].par, tab[2].par, tab[3].par, tab[4].par, tab[5].par, tab[6].par, tab[7].par} = 8'b10010110;
    {tab[8].par, tab[9].par, tab[10].par, tab[11].par, tab[12].par, tab[13].par, tab[14].par, tab[15].par} = 8'b01101001;
    // reset state
    @(posedge clk) #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk) #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sat", out_sat, 0);
    rst_n = 1;
    @(posedge clk) #1;
    chk("post_rst_in_ready", in_ready, 1);
    // exhaustive one-beat frames, back to back
    for (int b = 0; b < 2; b++) begin
      t0 = cyc;
      for (int i = b * 8; i < b * 8 + 8; i++) begin
        e.par = tab[i].par; e.n = 1;
        sb.push_back(e);
        beat(tab[i].data, 1, tab[i].mode, 0);
      end
      chk("throughput_cycles", cyc - t0, 8);
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    // three-beat frame, mode toggled mid-frame is ignored
    beat(3'b001, 0, 0, 1);
    beat(3'b011, 0, 1, 1);
    beat(3'b111, 1, 1, 1);
    idle();
    @(posedge clk) #1;
    // backpressure with a result pending
    out_ready = 0;
    beat(3'b001, 1, 0, 1);
    in_valid = 1; in_data = 3'b111; in_last = 1; mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_parity", out_parity, 0);
      chk("hold_count", out_count, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_in_ready2", in_ready2, 0);
      @(posedge clk) #1;
    end
    e.par = 1; e.n = 1;
    sb.push_back(e);
    out_ready = 1;
    @(negedge clk) chk("release_in_ready", in_ready, 1);
    @(posedge clk) #1;
    idle();
    chk("no_bubble_valid", out_valid, 1);
    @(posedge clk) #1;
    // saturation on the narrow counter
    for (int i = 0; i < 5; i++) beat(3'b001, i == 4, 1, 1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    // reset mid-frame drops the partial frame
    beat(3'b001, 0, 0, 1);
    beat(3'b011, 0, 0, 1);
    idle();
    rst_n = 0;
    m_acc = 0; m_n = 0;
    @(posedge clk) #1;
    rst_n = 1;
    chk("midrst_out_valid", out_valid, 0);
    beat(3'b000, 1, 0, 1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
